// File: rtl/idli_sqi_ctl_pkg.sv
// Shared types and constants for the dual SQI memory sequencer.
//   sqi_state_t : sequencer states
//   sqi_out_t   : registered output bundle driven to the memories and data buffer
//   ctr_t       : slice counter handed to the SQI data buffer
package idli_sqi_ctl_pkg;

  localparam int unsigned SQI_ADDR_W  = 24;
  localparam int unsigned SQI_WORD_W  = 16;
  localparam int unsigned SQI_CMD_W   = 8;
  localparam int unsigned SQI_SR_W    = SQI_CMD_W + SQI_ADDR_W;
  localparam int unsigned SQI_NIB_W   = 4;
  localparam int unsigned SQI_CTR_W   = 2;
  localparam int unsigned SQI_PHASE_W = 3;

  localparam logic [SQI_CMD_W-1:0] SQI_CMD_READ  = 8'h03;
  localparam logic [SQI_CMD_W-1:0] SQI_CMD_WRITE = 8'h02;
  localparam logic [SQI_CMD_W-1:0] SQI_CMD_EQIO  = 8'h38;

  typedef logic [SQI_CTR_W-1:0] ctr_t;

  typedef enum logic [2:0] {
    SQI_INIT,
    SQI_DESEL,
    SQI_CMD,
    SQI_ADDR,
    SQI_DUMMY,
    SQI_DATA,
    SQI_IDLE
  } sqi_state_t;

  typedef struct packed {
    logic                 cs;
    logic                 sck_en;
    logic                 sio_oe;
    logic [SQI_NIB_W-1:0] sio;
    logic                 data;
    ctr_t                 ctr;
    logic                 rdy;
  } sqi_out_t;

  // EQIO is sent while the parts are still in serial mode: one bit per
  // clock on SIO[0], so each command bit becomes its own nibble.
  function automatic logic [SQI_SR_W-1:0] sqi_serial_nibbles(input logic [SQI_CMD_W-1:0] b);
    logic [SQI_SR_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(SQI_CMD_W); i++) begin
      r[i*SQI_NIB_W +: SQI_NIB_W] = {3'b000, b[i]};
    end
    return r;
  endfunction

  // Quad command followed by the 24-bit byte address of a 16-bit word.
  function automatic logic [SQI_SR_W-1:0] sqi_cmd_word(input logic wr,
                                                       input logic [SQI_WORD_W-1:0] addr);
    logic [SQI_CMD_W-1:0] cmd;
    cmd = wr ? SQI_CMD_WRITE : SQI_CMD_READ;
    return {cmd, 7'b0000000, addr, 1'b0};
  endfunction

endpackage

// File: rtl/idli_sqi_ctl_m.sv
// Sequencer for the low/high nibble SQI memory pair sharing CS, SCK and the
// command/address stream. Puts both parts in quad mode after reset, then
// issues read/write commands on each redirect and parks in the data phase.
// Ports:
//   i_ctl_gck, i_ctl_rst          : clock, synchronous active-high reset
//   i_ctl_redirect/addr/wr_en     : start a new access at a word address
//   o_ctl_cs, o_ctl_sck_en        : chip-select (active-low), SCK gate
//   o_ctl_sio_oe, o_ctl_sio       : controller-driven nibble and its enable
//   o_ctl_data, o_ctl_ctr         : data phase flag and buffer slice counter
//   o_ctl_rdy                     : initialised and no command in flight
module idli_sqi_ctl_m
  import idli_sqi_ctl_pkg::*;
(
  input  logic                  i_ctl_gck,
  input  logic                  i_ctl_rst,
  input  logic                  i_ctl_redirect,
  input  logic [SQI_WORD_W-1:0] i_ctl_addr,
  input  logic                  i_ctl_wr_en,
  output logic                  o_ctl_cs,
  output logic                  o_ctl_sck_en,
  output logic                  o_ctl_sio_oe,
  output logic [SQI_NIB_W-1:0]  o_ctl_sio,
  output logic                  o_ctl_data,
  output ctr_t                  o_ctl_ctr,
  output logic                  o_ctl_rdy
);

  localparam sqi_out_t OUT_RST = '{cs: 1'b1, sck_en: 1'b0, sio_oe: 1'b0, sio: 4'h0,
                                   data: 1'b0, ctr: 2'b00, rdy: 1'b0};

  sqi_state_t             state_q, state_d;
  logic [SQI_PHASE_W-1:0] phase_q, phase_d;
  logic [SQI_SR_W-1:0]    sr_q, sr_d;
  logic [SQI_WORD_W-1:0]  addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic                   pend_q, pend_d;
  logic                   run_q;
  sqi_out_t               out_q, out_d;

  // State, datapath and output registers.
  always_ff @(posedge i_ctl_gck) begin
    if (i_ctl_rst) begin
      state_q <= SQI_INIT;
      phase_q <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      run_q   <= 1'b1;
      out_q   <= out_d;
    end
  end

  // Next state, plus outputs for the state being entered so they register
  // in step with it.
  always_comb begin
    state_d = state_q;
    phase_d = SQI_PHASE_W'(phase_q + SQI_PHASE_W'(1));
    sr_d    = sr_q << SQI_NIB_W;
    addr_d  = addr_q;
    wr_d    = wr_q;
    pend_d  = pend_q;
    out_d   = OUT_RST;

    // Any redirect replaces the target; the last one before CMD wins.
    if (i_ctl_redirect) begin
      addr_d = i_ctl_addr;
      wr_d   = i_ctl_wr_en;
      pend_d = 1'b1;
    end

    if (!run_q) begin
      state_d = SQI_INIT;
      phase_d = '0;
      sr_d    = sqi_serial_nibbles(SQI_CMD_EQIO);
    end else if (i_ctl_redirect && (state_q != SQI_INIT)) begin
      state_d = SQI_DESEL;
      phase_d = '0;
    end else begin
      unique case (state_q)
        SQI_INIT: begin
          if (phase_q == SQI_PHASE_W'(7)) begin
            state_d = SQI_DESEL;
            phase_d = '0;
          end
        end
        SQI_DESEL: begin
          phase_d = '0;
          if (pend_q) begin
            state_d = SQI_CMD;
            sr_d    = sqi_cmd_word(wr_q, addr_q);
            pend_d  = 1'b0;
          end else begin
            state_d = SQI_IDLE;
          end
        end
        SQI_CMD: begin
          if (phase_q == SQI_PHASE_W'(1)) begin
            state_d = SQI_ADDR;
            phase_d = '0;
          end
        end
        SQI_ADDR: begin
          if (phase_q == SQI_PHASE_W'(5)) begin
            state_d = wr_q ? SQI_DATA : SQI_DUMMY;
            phase_d = '0;
          end
        end
        SQI_DUMMY: begin
          if (phase_q == SQI_PHASE_W'(1)) begin
            state_d = SQI_DATA;
            phase_d = '0;
          end
        end
        SQI_DATA: phase_d = '0;
        SQI_IDLE: phase_d = '0;
        default: begin
          state_d = SQI_DESEL;
          phase_d = '0;
        end
      endcase
    end

    unique case (state_d)
      SQI_INIT, SQI_CMD, SQI_ADDR: begin
        out_d.cs     = 1'b0;
        out_d.sck_en = 1'b1;
        out_d.sio_oe = 1'b1;
        out_d.sio    = sr_d[SQI_SR_W-1 -: SQI_NIB_W];
      end
      SQI_DUMMY: begin
        out_d.cs     = 1'b0;
        out_d.sck_en = 1'b1;
      end
      SQI_DATA: begin
        out_d.cs     = 1'b0;
        out_d.sck_en = 1'b1;
        out_d.data   = 1'b1;
        out_d.rdy    = 1'b1;
        // Buffer slice count restarts with every new data phase.
        out_d.ctr    = (state_q == SQI_DATA) ? ctr_t'(out_q.ctr + ctr_t'(1)) : '0;
      end
      SQI_IDLE: out_d.rdy = 1'b1;
      default: ;
    endcase
  end

  assign o_ctl_cs     = out_q.cs;
  assign o_ctl_sck_en = out_q.sck_en;
  assign o_ctl_sio_oe = out_q.sio_oe;
  assign o_ctl_sio    = out_q.sio;
  assign o_ctl_data   = out_q.data;
  assign o_ctl_ctr    = out_q.ctr;
  assign o_ctl_rdy    = out_q.rdy;

endmodule

// File: tb/tb_idli_sqi_ctl_m.sv
// Self-checking bench for idli_sqi_ctl_m. Each scenario queues per-cycle
// stimulus together with the outputs expected one cycle later, then drains
// the queue against the DUT.
module tb_idli_sqi_ctl_m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] addr = '0;
  logic        wr_en = 1'b0;
  logic        cs, sck_en, sio_oe, data, rdy;
  logic [3:0]  sio;
  logic [1:0]  ctr;

  idli_sqi_ctl_m dut (
    .i_ctl_gck      (clk),
    .i_ctl_rst      (rst),
    .i_ctl_redirect (redirect),
    .i_ctl_addr     (addr),
    .i_ctl_wr_en    (wr_en),
    .o_ctl_cs       (cs),
    .o_ctl_sck_en   (sck_en),
    .o_ctl_sio_oe   (sio_oe),
    .o_ctl_sio      (sio),
    .o_ctl_data     (data),
    .o_ctl_ctr      (ctr),
    .o_ctl_rdy      (rdy)
  );

  always #5 clk = ~clk;

  // {cs, sck_en, sio_oe, sio, data, ctr, rdy}
  logic [10:0] outv;
  assign outv = {cs, sck_en, sio_oe, sio, data, ctr, rdy};

  typedef struct packed {
    logic        rst;
    logic        redir;
    logic        wr;
    logic [15:0] addr;
    logic [10:0] exp;
  } step_t;

  step_t sb[$];
  int    vecs = 0;
  int    errs = 0;
  int    cyc  = 0;

  function automatic logic [10:0] ov(input logic c, input logic k, input logic o,
                                     input logic [3:0] n, input logic d,
                                     input logic [1:0] t, input logic r);
    return {c, k, o, n, d, t, r};
  endfunction

  localparam logic [10:0] V_RST   = 11'b1_0_0_0000_0_00_0;
  localparam logic [10:0] V_DESEL = 11'b1_0_0_0000_0_00_0;
  localparam logic [10:0] V_IDLE  = 11'b1_0_0_0000_0_00_1;
  localparam logic [10:0] V_DUMMY = 11'b0_1_0_0000_0_00_0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic r, input logic rd, input logic w,
                      input logic [15:0] a, input logic [10:0] e);
    step_t s;
    s.rst = r; s.redir = rd; s.wr = w; s.addr = a; s.exp = e;
    sb.push_back(s);
  endtask

  // INIT (EQIO bits on SIO[0]) then DESEL; optional redirect at INIT cycle redir_at.
  task automatic add_init(input int redir_at, input logic [15:0] a, input logic w);
    logic [7:0] eqio;
    eqio = 8'h38;
    for (int k = 0; k < 8; k++)
      push(1'b0, k == redir_at, w, a, ov(1'b0, 1'b1, 1'b1, {3'b000, eqio[7-k]}, 1'b0, 2'b00, 1'b0));
    push(1'b0, 1'b0, 1'b0, '0, V_DESEL);
  endtask

  task automatic add_redirect(input logic [15:0] a, input logic w);
    push(1'b0, 1'b1, w, a, V_DESEL);
  endtask

  // CMD, ADDR, DUMMY (reads) and ndata DATA cycles; cut>0 truncates the list.
  task automatic add_body(input logic [15:0] a, input logic w, input int ndata, input int cut);
    logic [7:0]  cmd;
    logic [23:0] ba;
    logic [10:0] e[$];
    cmd = w ? 8'h02 : 8'h03;
    ba  = {7'b0, a, 1'b0};
    e.push_back(ov(1'b0, 1'b1, 1'b1, cmd[7:4], 1'b0, 2'b00, 1'b0));
    e.push_back(ov(1'b0, 1'b1, 1'b1, cmd[3:0], 1'b0, 2'b00, 1'b0));
    for (int i = 0; i < 6; i++)
      e.push_back(ov(1'b0, 1'b1, 1'b1, ba[23-4*i -: 4], 1'b0, 2'b00, 1'b0));
    if (!w) begin
      e.push_back(V_DUMMY);
      e.push_back(V_DUMMY);
    end
    for (int i = 0; i < ndata; i++)
      e.push_back(ov(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 2'(i), 1'b1));
    for (int i = 0; i < e.size(); i++) begin
      if (cut > 0 && i >= cut) break;
      push(1'b0, 1'b0, 1'b0, '0, e[i]);
    end
  endtask

  task automatic test_reset();
    push(1'b1, 1'b0, 1'b0, '0, V_RST);
    push(1'b1, 1'b0, 1'b0, '0, V_RST);
    add_init(-1, '0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, '0, V_IDLE);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      rst = s.rst; redirect = s.redir; addr = s.addr; wr_en = s.wr;
      tick();
      vecs++;
      if (outv !== s.exp) begin
        errs++;
        $display("FAIL reset cyc%0d got %h exp %h", cyc, outv, s.exp);
      end
    end
  endtask

  task automatic test_read();
    add_redirect(16'h1234, 1'b0);
    add_body(16'h1234, 1'b0, 5, 0);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      rst = s.rst; redirect = s.redir; addr = s.addr; wr_en = s.wr;
      tick();
      vecs++;
      if (outv !== s.exp) begin
        errs++;
        $display("FAIL read cyc%0d got %h exp %h", cyc, outv, s.exp);
      end
    end
  endtask

  task automatic test_write();
    add_redirect(16'hFFFF, 1'b1);
    add_body(16'hFFFF, 1'b1, 3, 0);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      rst = s.rst; redirect = s.redir; addr = s.addr; wr_en = s.wr;
      tick();
      vecs++;
      if (outv !== s.exp) begin
        errs++;
        $display("FAIL write cyc%0d got %h exp %h", cyc, outv, s.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    add_redirect(16'h0010, 1'b0);
    add_body(16'h0010, 1'b0, 0, 5);
    add_redirect(16'h0020, 1'b0);
    add_body(16'h0020, 1'b0, 4, 0);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      rst = s.rst; redirect = s.redir; addr = s.addr; wr_en = s.wr;
      tick();
      vecs++;
      if (outv !== s.exp) begin
        errs++;
        $display("FAIL back_to_back cyc%0d got %h exp %h", cyc, outv, s.exp);
      end
    end
  endtask

  task automatic test_init_redirect();
    push(1'b1, 1'b0, 1'b0, '0, V_RST);
    add_init(3, 16'hA5C3, 1'b1);
    add_body(16'hA5C3, 1'b1, 2, 0);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      rst = s.rst; redirect = s.redir; addr = s.addr; wr_en = s.wr;
      tick();
      vecs++;
      if (outv !== s.exp) begin
        errs++;
        $display("FAIL init_redirect cyc%0d got %h exp %h", cyc, outv, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    add_redirect(16'h4321, 1'b0);
    add_body(16'h4321, 1'b0, 0, 4);
    push(1'b1, 1'b0, 1'b0, '0, V_RST);
    add_init(-1, '0, 1'b0);
    for (int i = 0; i < 2; i++) push(1'b0, 1'b0, 1'b0, '0, V_IDLE);
    while (sb.size() != 0) begin
      step_t s;
      s = sb.pop_front();
      rst = s.rst; redirect = s.redir; addr = s.addr; wr_en = s.wr;
      tick();
      vecs++;
      if (outv !== s.exp) begin
        errs++;
        $display("FAIL reset_mid cyc%0d got %h exp %h", cyc, outv, s.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_init_redirect();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/idli_sqi_ctl_m.md
# idli_sqi_ctl_m

Sequencer for the pair of SQI memories (low-nibble and high-nibble parts) that share one chip-select, clock enable and command/address stream. After reset it switches both memories into quad mode. On each redirect it issues a quad read or write command with the target address, then holds the memories in the sequential data phase. It drives chip-select, SCK enable, the shared command/address nibbles and the slice counter consumed by the SQI data buffer.

## Interface
Parameters: none; widths come from the package.
- i_ctl_gck  in  1  core clock
- i_ctl_rst  in  1  reset, synchronous, active-high
- i_ctl_redirect  in  1  start a new access at i_ctl_addr (single-cycle strobe)
- i_ctl_addr  in  16  word address, sampled when i_ctl_redirect=1
- i_ctl_wr_en  in  1  access type, sampled with redirect (1=write, 0=read)
- o_ctl_cs  out  1  chip-select to both memories, active-low
- o_ctl_sck_en  out  1  SCK gate; both memories clock when 1
- o_ctl_sio_oe  out  1  controller drives SIO (command/address/EQIO)
- o_ctl_sio  out  4  nibble driven to both memories when o_ctl_sio_oe=1
- o_ctl_data  out  1  data phase active; SIO belongs to the data buffer
- o_ctl_ctr  out  ctr_t (2)  slice counter for the buffer
- o_ctl_rdy  out  1  init complete, no command in flight

## Operation
- All outputs are registered. Reset values: cs=1, sck_en=0, sio_oe=0, sio=0, data=0, ctr=0, rdy=0.
- States: INIT, DESEL, CMD, ADDR, DUMMY, DATA, IDLE.
- INIT runs the cycle after reset deasserts and lasts 8 cycles. Each cycle drives cs=0, sck_en=1, sio_oe=1 and sio={3'b0, bit}. Bits are EQIO 0x38, MSB first: 0,0,1,1,1,0,0,0. INIT then goes to DESEL.
- DESEL lasts 1 cycle with cs=1, sck_en=0 and sio_oe=0.
  - If a redirect is pending, go to CMD.
  - Otherwise go to IDLE (rdy=1).
- Redirect handling:
  - Redirect during INIT sets a pending flag and latches addr and wr_en; it is serviced after INIT's DESEL.
  - Redirect in any other state (including DESEL, CMD, ADDR, DUMMY, DATA and IDLE) latches addr and wr_en, then forces DESEL next cycle.
  - A later redirect overwrites an earlier latched one. Only the last one wins.
- CMD lasts 2 cycles with cs=0, sck_en=1 and sio_oe=1. Nibbles are the high then low nibble of 0x03 (read) or 0x02 (write).
- ADDR lasts 6 cycles. It drives the 24-bit byte address {7'b0, addr, 1'b0}, most significant nibble first.
- DUMMY applies to reads only and lasts 2 cycles with sio_oe=0 and sck_en=1. Writes skip DUMMY.
- DATA: cs=0, sck_en=1, sio_oe=0, data=1.
  - ctr starts at 0 and increments by 1 each cycle, wrapping 3→0.
  - DATA continues indefinitely; the memories auto-increment the address.
  - Exit is by redirect only.
- ctr holds 0 outside DATA.
- rdy=1 only in IDLE and DATA. Asserting redirect clears rdy in the next cycle.
- Reset mid-sequence: abandon immediately. Next cycle shows reset values; INIT is re-run.

## Timing
- Redirect sampled at cycle N:
  - N+1: DESEL (cs=1).
  - N+2: CMD nibble 0x0.
  - N+3: CMD nibble 0x3 or 0x2.
  - N+4..N+9: ADDR.
- Read: N+10..N+11 DUMMY; first DATA cycle at N+12 with ctr=0.
- Write: first DATA cycle at N+10 with ctr=0.
- Post-reset, reset low at cycle R:
  - R+1..R+8: INIT.
  - R+9: DESEL.
  - R+10: IDLE with rdy=1, or CMD if a redirect is pending.
- cs deasserts for exactly one cycle between any two accesses.

## Structure
- The shared package gains:
  - enum sqi_state_t for the seven states.
  - Constants SQI_CMD_READ=8'h03, SQI_CMD_WRITE=8'h02, SQI_CMD_EQIO=8'h38.
  - SQI_ADDR_W=24.
- A single 32-bit shift register, loaded with {cmd, byte address} and shifted 4 bits per cycle, feeds o_ctl_sio. A 3-bit phase counter bounds each state.
- No sub-module. Logic stays inline: one FSM plus counters.

## Test plan
- Reset, then idle. Checks: INIT sio[0] sequence 0,0,1,1,1,0,0,0 with cs=0; DESEL at R+9; rdy=1 at R+10 and held.
- Read redirect, addr=0x1234, from IDLE. Checks: sio sequence 0,3,0,0,2,4,6,8; 2 dummy cycles with oe=0; data=1 at N+12; ctr runs 0,1,2,3,0.
- Write redirect, addr=0xFFFF. Checks: sio sequence 0,2,0,1,F,F,F,E; data=1 at N+10 with no dummy cycles.
- Redirect to 0x0010 during DATA, then a second redirect to 0x0020 during its ADDR phase. Checks: two one-cycle DESELs; the final access uses 0x0020.
- Redirect at R+3 (mid-INIT). Checks: INIT completes unchanged; CMD starts at R+10; rdy stays 0 until DATA.
- Reset asserted mid-ADDR. Checks: next cycle cs=1, sck_en=0, data=0, rdy=0; INIT restarts.
